// File: rtl/x_in_pkg.sv
// -----------------------------------------------------------------------------
// x_in_pkg
// Shared definitions for the x_in input conditioner: the conditioner state
// encoding and the default debounce / auto-repeat timing constants.
// -----------------------------------------------------------------------------
package x_in_pkg;

  // Conditioner state encoding (also exposed on the state debug port).
  localparam logic [1:0] IDLE         = 2'b00;
  localparam logic [1:0] PRESS_WAIT   = 2'b01;
  localparam logic [1:0] HELD         = 2'b10;
  localparam logic [1:0] RELEASE_WAIT = 2'b11;

  // Default timing.
  localparam int DEBOUNCE_CYCLES_DEF = 4;  // equal samples to accept a change
  localparam int REPEAT_CYCLES_DEF   = 8;  // auto-repeat period while held

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous level: d -> s1 -> q.
// Ports:
//   clk  - destination clock, rising edge
//   rst  - asynchronous active-high reset, clears both flops
//   d    - asynchronous input level
//   q    - level synchronised to clk (two cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;  // first stage; may go metastable, never used outside this module

  // NOTE: clocked state uses non-blocking assignments so both stages sample
  // their inputs from before the edge; blocking here would collapse s1 and q
  // into a single flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/x_in_conditioner.sv
// -----------------------------------------------------------------------------
// x_in_conditioner
// Input conditioner for a raw pushbutton feeding the x_in pulse-counting FSM.
// Synchronises raw_in, debounces it with a consecutive-sample counter and
// emits one single-cycle x_out pulse per accepted press.
//
// Optional feature: define AUTO_REPEAT_EN to emit additional x_out pulses every
// REPEAT_CYCLES cycles while the button stays held.
//
// Parameters:
//   DEBOUNCE_CYCLES - equal synchronised samples to accept a change (2..65535)
//   REPEAT_CYCLES   - auto-repeat period in cycles (>= 2, AUTO_REPEAT_EN only)
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous active-high reset
//   raw_in  - unsynchronised button level
//   x_out   - one-cycle pulse per accepted press (drives downstream x_in)
//   x_level - debounced button level
//   state   - current conditioner state (debug)
// -----------------------------------------------------------------------------
module x_in_conditioner
  import x_in_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_in,
  output logic       x_out,
  output logic       x_level,
  output logic [1:0] state
);

  localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Reject illegal parameter sets at elaboration.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 || REPEAT_CYCLES < 2) begin : g_bad_param
    $error("x_in_conditioner: DEBOUNCE_CYCLES or REPEAT_CYCLES out of range");
  end

  logic             s;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [1:0]       state_d;
  logic             x_level_d;
  logic             press_pulse;
  logic             pulse_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (raw_in),
    .q   (s)
  );

  // Debounce FSM next-state logic. The counter counts consecutive samples
  // that agree with the pending level and saturates at CNT_MAX by construction
  // (reaching it always moves the FSM on and clears it).
  always_comb begin
    // NOTE: every output of this block gets a default first; without it any
    // path that skips an assignment would infer a latch.
    state_d     = state;
    cnt_d       = cnt;
    x_level_d   = x_level;
    press_pulse = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;            // bounce: drop back without a pulse
          cnt_d   = '0;
        end else if (cnt == CNT_MAX) begin
          state_d     = HELD;
          x_level_d   = 1'b1;
          press_pulse = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = HELD;            // release bounce: still held, no new pulse
          cnt_d   = '0;
        end else if (cnt == CNT_MAX) begin
          state_d   = IDLE;
          x_level_d = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        x_level_d = 1'b0;
      end
    endcase
  end

`ifdef AUTO_REPEAT_EN
  localparam int             RPT_W   = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_cnt, rpt_cnt_d;
  logic             rpt_fire;

  // The repeat counter only runs while staying in HELD, so it is cleared both
  // on the edge that enters HELD and on the edge that leaves it.
  always_comb begin
    rpt_cnt_d = '0;
    rpt_fire  = 1'b0;
    if (state == HELD && state_d == HELD) begin
      if (rpt_cnt == RPT_MAX) begin
        rpt_fire = 1'b1;
      end else begin
        rpt_cnt_d = rpt_cnt + RPT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rpt_cnt <= '0;
    else     rpt_cnt <= rpt_cnt_d;
  end

  assign pulse_d = press_pulse | rpt_fire;
`else
  assign pulse_d = press_pulse;
`endif

  // x_out defaults low each cycle, so it is high for exactly one cycle unless
  // a new pulse is requested on the following edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      x_level <= 1'b0;
      x_out   <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      x_level <= x_level_d;
      x_out   <= pulse_d;
    end
  end

endmodule

// File: tb/tb_x_in_conditioner.sv
// -----------------------------------------------------------------------------
// tb_x_in_conditioner
// Directed self-checking bench for x_in_conditioner (default parameters).
// Inputs are driven and outputs sampled on the falling clock edge. In the
// per-cycle loops, iteration i is observed just after rising edge t0+i, where
// t0 is the first edge that samples the new raw_in value.
// -----------------------------------------------------------------------------
module tb_x_in_conditioner;
  import x_in_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       raw_in = 1'b0;
  logic       x_out;
  logic       x_level;
  logic [1:0] state;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  x_in_conditioner dut (
    .clk     (clk),
    .rst     (rst),
    .raw_in  (raw_in),
    .x_out   (x_out),
    .x_level (x_level),
    .state   (state)
  );

  // Return to a quiet IDLE with the synchroniser flushed.
  task automatic settle_idle;
    raw_in = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [3:0] obs;
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      raw_in = 1'($urandom_range(0, 1));
      @(negedge clk);
      obs = {state, x_level, x_out};
      chk_cnt++;
      if (obs !== 4'b0000) $display("FAIL reset_hold[%0d]: got %b expected 0000", i, obs);
      else pass_cnt++;
    end
    raw_in = 1'b0;
    rst    = 1'b0;
    repeat (4) @(negedge clk);
    obs = {state, x_level, x_out};
    chk_cnt++;
    if (obs !== 4'b0000) $display("FAIL reset_release: got %b expected 0000", obs);
    else pass_cnt++;
  endtask

  // Clean press held 20 cycles, then clean release.
  task automatic test_press_release;
    logic [1:0] es;
    logic [3:0] obs, exp;
    settle_idle();
    raw_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      es  = (i < 2) ? IDLE : (i < 5) ? PRESS_WAIT : HELD;
      exp = {es, 1'(i >= 5), 1'(i == 5)};
      obs = {state, x_level, x_out};
      chk_cnt++;
      if (obs !== exp) $display("FAIL press[%0d]: got %b expected %b", i, obs, exp);
      else pass_cnt++;
    end
    raw_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      es  = (i < 2) ? HELD : (i < 5) ? RELEASE_WAIT : IDLE;
      exp = {es, 1'(i < 5), 1'b0};
      obs = {state, x_level, x_out};
      chk_cnt++;
      if (obs !== exp) $display("FAIL release[%0d]: got %b expected %b", i, obs, exp);
      else pass_cnt++;
    end
  endtask

  // Press bounce: high 2, low 1, high 1, then low. Never qualifies.
  task automatic test_bounce;
    logic       bseq [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [1:0] bexp [10] = '{IDLE, IDLE, PRESS_WAIT, PRESS_WAIT, IDLE,
                              PRESS_WAIT, IDLE, IDLE, IDLE, IDLE};
    logic [3:0] obs, exp;
    settle_idle();
    for (int i = 0; i < 10; i++) begin
      raw_in = bseq[i];
      @(negedge clk);
      exp = {bexp[i], 2'b00};
      obs = {state, x_level, x_out};
      chk_cnt++;
      if (obs !== exp) $display("FAIL bounce[%0d]: got %b expected %b", i, obs, exp);
      else pass_cnt++;
    end
  endtask

  // Release with a 2-cycle re-bounce high: back to HELD, no second pulse.
  task automatic test_release_rebounce;
    logic       rseq [12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [1:0] rexp [12] = '{HELD, HELD, RELEASE_WAIT, RELEASE_WAIT, HELD, HELD,
                              RELEASE_WAIT, RELEASE_WAIT, RELEASE_WAIT, IDLE, IDLE, IDLE};
    logic [3:0] obs, exp;
    settle_idle();
    raw_in = 1'b1;
    repeat (10) @(negedge clk);
    chk_cnt++;
    if (state !== HELD) $display("FAIL rebounce_setup: got %b expected %b", state, HELD);
    else pass_cnt++;
    for (int i = 0; i < 12; i++) begin
      raw_in = rseq[i];
      @(negedge clk);
      exp = {rexp[i], 1'(i < 9), 1'b0};
      obs = {state, x_level, x_out};
      chk_cnt++;
      if (obs !== exp) $display("FAIL rebounce[%0d]: got %b expected %b", i, obs, exp);
      else pass_cnt++;
    end
  endtask

  // Reset asserted between clock edges must act before the next rising edge.
  task automatic test_async_reset;
    logic [3:0] obs;
    settle_idle();
    raw_in = 1'b1;
    repeat (4) @(negedge clk);
    chk_cnt++;
    if (state !== PRESS_WAIT || dut.cnt !== 3'd2)
      $display("FAIL arst_setup: got state %b cnt %0d expected %b cnt 2", state, dut.cnt, PRESS_WAIT);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    obs = {state, x_level, x_out};
    chk_cnt++;
    if (obs !== 4'b0000 || dut.cnt !== 3'd0)
      $display("FAIL arst_press_wait: got %b cnt %0d expected 0000 cnt 0", obs, dut.cnt);
    else pass_cnt++;
    raw_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    settle_idle();

    raw_in = 1'b1;
    repeat (8) @(negedge clk);
    chk_cnt++;
    if ({state, x_level} !== {HELD, 1'b1}) $display("FAIL arst_held_setup: got %b expected 101", {state, x_level});
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    obs = {state, x_level, x_out};
    chk_cnt++;
    if (obs !== 4'b0000) $display("FAIL arst_held: got %b expected 0000", obs);
    else pass_cnt++;
    raw_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Long hold: with auto-repeat a pulse every 8 cycles after the press pulse,
  // otherwise only the press pulse. Never a pulse on release.
  task automatic test_long_hold;
    int   pulses;
    logic exp;
    settle_idle();
    pulses = 0;
    raw_in = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
`ifdef AUTO_REPEAT_EN
      exp = (i >= 5) && (((i - 5) % 8) == 0);
`else
      exp = (i == 5);
`endif
      if (x_out === 1'b1) pulses++;
      chk_cnt++;
      if (x_out !== exp) $display("FAIL hold_pulse[%0d]: got %b expected %b", i, x_out, exp);
      else pass_cnt++;
    end
`ifdef AUTO_REPEAT_EN
    chk_cnt++;
    if (pulses != 5) $display("FAIL hold_pulse_count: got %0d expected 5", pulses);
    else pass_cnt++;
`else
    chk_cnt++;
    if (pulses != 1) $display("FAIL hold_pulse_count: got %0d expected 1", pulses);
    else pass_cnt++;
`endif
    raw_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk_cnt++;
      if (x_out !== 1'b0) $display("FAIL hold_release[%0d]: got %b expected 0", i, x_out);
      else pass_cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_press_release();
    test_bounce();
    test_release_rebounce();
    test_async_reset();
    test_long_hold();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/x_in_conditioner.md
Name: x_in_conditioner

Overview:
- Upstream input-conditioning stage for the x_in pulse-counting FSM.
- Takes a raw, asynchronous, bouncy pushbutton/switch level and performs three steps:
  - synchronises it to clk;
  - debounces it with a consecutive-sample counter;
  - emits exactly one single-cycle x_out pulse per accepted press.
- x_out connects directly to the downstream FSM's x_in, so one physical press advances that FSM by exactly one state.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive equal synchronised samples required to accept a level change; legal range 2..65535.
- CNT_W, $clog2(DEBOUNCE_CYCLES)+1, width of the debounce counter; derived, not overridden.
- REPEAT_CYCLES, 8, cycles between repeat pulses while held; only used with AUTO_REPEAT_EN; legal minimum 2.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- raw_in  input  1  unsynchronised button level.
- x_out  output  1  one-cycle pulse on each accepted press; feeds downstream x_in.
- x_level  output  1  debounced level.
- state  output  2  current conditioner state, for debug/observation.

Behaviour:
- Reset:
  - rst is asynchronous, active-high; asserting it at any time forces the reset values immediately.
  - Reset values: both synchroniser flops 0, counter 0, state IDLE, x_out 0, x_level 0.
  - Deassertion mid-bounce restarts qualification from IDLE.
- Synchroniser: two flops, raw_in -> s1 -> s. Only s is used by the FSM.
- State encoding: IDLE=2'b00, PRESS_WAIT=2'b01, HELD=2'b10, RELEASE_WAIT=2'b11.
- IDLE:
  - s=1 -> PRESS_WAIT, cnt=1.
  - Otherwise stay, cnt=0.
- PRESS_WAIT:
  - s=0 -> IDLE, cnt=0 (bounce rejected, no pulse).
  - s=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD, x_level<=1, x_out<=1, cnt=0.
  - Otherwise cnt++.
- HELD:
  - s=0 -> RELEASE_WAIT, cnt=1.
  - Otherwise stay.
- RELEASE_WAIT:
  - s=1 -> HELD, cnt=0.
  - s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, x_level<=0, cnt=0.
  - Otherwise cnt++.
  - Release never produces a pulse.
- Registered outputs:
  - x_out is registered and high for exactly one cycle, then cleared on the next edge unless re-asserted.
  - x_level changes on the same edge the state enters HELD or IDLE.
- Latency: if raw_in is first sampled high at edge t0 and stays stable, x_out and x_level are high after edge t0+1+DEBOUNCE_CYCLES. With the default, that is 5 edges.
- Glitch rejection: a glitch shorter than DEBOUNCE_CYCLES synchronised samples never changes x_level or x_out.
- Counter: never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Default case: unreachable encodings -> IDLE, outputs 0.

Optional Feature:
- AUTO_REPEAT_EN defined:
  - While in HELD, a separate repeat counter increments every cycle.
  - When it reaches REPEAT_CYCLES-1, x_out pulses for one cycle and the counter returns to 0.
  - The counter is cleared on entering HELD, on leaving HELD, and on rst.
  - With the defaults, the first repeat pulse appears 8 cycles after the press pulse and repeats every 8 cycles.
- Not defined: no repeat counter exists; exactly one pulse per press.

Decomposition:
- Shared package x_in_pkg holds:
  - the state localparams IDLE, PRESS_WAIT, HELD, RELEASE_WAIT;
  - the default DEBOUNCE_CYCLES/REPEAT_CYCLES constants.
- One sub-module, sync_2ff (clk, rst, d, q): the two-flop synchroniser, reusable for other asynchronous inputs.
- The debounce FSM, counter and pulse logic stay in x_in_conditioner.

Test Plan (default parameters, AUTO_REPEAT_EN off unless stated):
- rst high, toggle raw_in randomly -> x_out=0, x_level=0, state=00 throughout. Release rst with raw_in=0 -> state stays 00.
- raw_in 0->1 held for 20 cycles, first sampled at edge t0 -> state 01 after t0+2; x_out=1 only in the cycle after t0+5; x_level=1 from t0+5 onward; state=10.
- Bounce: raw_in high 2 cycles, low 1, high 1, low -> state returns to 00; x_out never 1, x_level stays 0.
- Press, then release with a 2-cycle re-bounce high during RELEASE_WAIT -> returns to HELD, no second pulse. A stable low then reaches IDLE 4 samples later.
- Assert rst during PRESS_WAIT (cnt=2) -> state=00, cnt=0, outputs 0 immediately, before the next clock edge.
- AUTO_REPEAT_EN defined, hold raw_in high 40 cycles -> press pulse, then repeat pulses 8, 16, 24… cycles later. Count pulses: 1 + floor((hold time in HELD)/8). No pulses after release.
